rgb_led_sequencer: RTL

//  Sequencer for the two RGB LEDs (led_out_4, led_out_5). Decodes a one-hot colour

---
 rtl/rgb_led_pkg.sv | 35 +++
 rtl/rgb_tick_gen.sv | 36 +++
 rtl/rgb_led_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/rgb_led_pkg.sv
// Shared definitions for the RGB LED sequencer.
//   Colour codes for the {B,G,R} LED pins, the switch mode codes, the FSM
//   state type, and the one-hot colour request decoder.
package rgb_led_pkg;

  localparam logic [2:0] C_OFF = 3'b000;
  localparam logic [2:0] C_R   = 3'b001;
  localparam logic [2:0] C_G   = 3'b010;
  localparam logic [2:0] C_B   = 3'b100;
  localparam logic [2:0] C_W   = 3'b111;

  localparam logic [1:0] M_STATIC = 2'b00;
  localparam logic [1:0] M_MIRROR = 2'b01;
  localparam logic [1:0] M_ALT    = 2'b10;
  localparam logic [1:0] M_CYCLE  = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // Anything other than a single valid one-hot request turns the LED off.
  function automatic logic [2:0] colour_decode(input logic [3:0] bin_in);
    logic [2:0] c;
    case (bin_in)
      4'b0001: c = C_R;
      4'b0010: c = C_G;
      4'b0100: c = C_B;
      4'b1000: c = C_W;
      default: c = C_OFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb_tick_gen.sv
// Step timer for the RGB LED sequencer.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the step (counter to 0, tick suppressed)
//   en   : count this cycle
//   tick : one-cycle pulse on the last cycle of each TICK_DIV-cycle step
module rgb_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             at_last;

  always_comb begin
    at_last = (tick_cnt == LAST);
    tick    = en && !clr && at_last;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= at_last ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_led_sequencer.sv
// Sequencer driving the two RGB LEDs from a one-hot colour request.
//   clk, rst          : system clock, synchronous active-high reset
//   en                : 1 = run, 0 = idle with both LEDs off
//   switch_1/switch_0 : mode select (static, mirror, alternate, auto-cycle)
//   bin_in            : one-hot colour request (R, G, B, W)
//   led_out_4/5       : RGB LEDs, bit0 R / bit1 G / bit2 B, 1 = on
//   step              : current sequence step (0..3)
//   tick              : pulse on the last cycle of each step
module rgb_led_sequencer
  import rgb_led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       switch_0,
  input  logic       switch_1,
  input  logic [3:0] bin_in,
  output logic [2:0] led_out_4,
  output logic [2:0] led_out_5,
  output logic [1:0] step,
  output logic       tick
);

  state_t     state, state_nxt;
  logic [1:0] mode_q;
  logic [2:0] colour_q;
  logic       run;
  logic       mode_chg;
  logic       cnt_en;
  logic       cnt_clr;

  // A mode change or leaving RUN restarts the pattern; both beat a
  // coincident tick because the timer suppresses tick while clr is high.
  always_comb begin
    run      = (state == S_RUN);
    mode_chg = run && ({switch_1, switch_0} != mode_q);
    cnt_en   = run && en && !rst;
    cnt_clr  = !cnt_en || mode_chg;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en)  state_nxt = S_RUN;
      S_RUN:   if (!en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= M_STATIC;
      colour_q <= C_OFF;
    end else begin
      state    <= state_nxt;
      mode_q   <= {switch_1, switch_0};
      colour_q <= colour_decode(bin_in);
    end
  end

  rgb_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      step <= '0;
    end else if (tick) begin
      step <= step + 2'd1;
    end
  end

  always_comb begin
    led_out_4 = C_OFF;
    led_out_5 = C_OFF;
    if (run) begin
      case (mode_q)
        M_STATIC: led_out_4 = colour_q;
        M_MIRROR: begin
          led_out_4 = colour_q;
          led_out_5 = colour_q;
        end
        M_ALT: begin
          if (step[0]) led_out_5 = colour_q;
          else         led_out_4 = colour_q;
        end
        default: begin
          case (step)
            2'd0:    led_out_4 = C_R;
            2'd1:    led_out_4 = C_G;
            2'd2:    led_out_4 = C_B;
            default: led_out_4 = C_W;
          endcase
          led_out_5 = led_out_4;
        end
      endcase
    end
  end

endmodule
